qupls4_uop_reader: RTL
======================

QUPLS4_UOP_READER -- requirements
Module: Qupls4_uop_reader

Interface
REQ-001 SHALL have parameter MWIDTH, default Qupls4_pkg::MWIDTH (4), meaning lanes per rename group.
REQ-002 SHALL have parameter QDEPTH, default 12, meaning micro-op queue depth.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-005 SHALL have port en, input, 1 bit: pipeline enable.
REQ-006 SHALL have port stomp, input, 1 bit: flush request from branch/exception.
REQ-007 SHALL have port q_count, input, 4 bits: valid micro-ops at queue head, 0..QDEPTH.
REQ-008 SHALL have port q_uop, input, micro_op_t[MWIDTH]: queue entries head..head+MWIDTH-1.
REQ-009 SHALL have port q_mark, input, 3 bits x MWIDTH: per-entry mark; bit0 first-of-instruction, bit1 last-of-instruction, bit2 serialize.
REQ-010 SHALL have port q_pop, output, 3 bits: entries consumed this cycle (combinational).
REQ-011 SHALL have port grp_v, output, 1 bit: rename group valid.
REQ-012 SHALL have port grp_rdy, input, 1 bit: rename accepts group.
REQ-013 SHALL have port grp_uop, output, micro_op_t[MWIDTH]: group payload.
REQ-014 SHALL have port grp_lane_v, output, MWIDTH bits: per-lane valid, contiguous from lane 0.
REQ-015 SHALL have port grp_seq, output, 8 bits: group sequence number.
REQ-016 SHALL have port drain_done, input, 1 bit: backend empty acknowledge.

Function
REQ-017 Take count k SHALL be min(q_count, MWIDTH), truncated so a serialize entry is alone: lane0 serialize -> k=1; else k = lanes preceding first serialize lane.
REQ-018 Load condition SHALL be en & state==RUN & !stomp & k>0 & (!grp_v | grp_rdy).
REQ-019 On load, q_pop SHALL equal k in the same cycle; otherwise q_pop SHALL be 0.
REQ-020 On load, grp_uop lanes 0..k-1 SHALL capture q_uop lanes 0..k-1, grp_lane_v SHALL be (1<<k)-1, grp_v SHALL be 1 next cycle; latency one cycle.
REQ-021 grp_v & grp_rdy without a load SHALL clear grp_v and grp_lane_v next cycle.
REQ-022 While grp_v & !grp_rdy, grp_uop, grp_lane_v, grp_seq SHALL hold stable.
REQ-023 grp_seq SHALL increment by 1 per load, wrapping 255->0.
REQ-024 States SHALL be RUN, DRAIN, FLUSH.
REQ-025 RUN->DRAIN when a serialize entry is loaded; no loads in DRAIN.
REQ-026 DRAIN->RUN when grp_v==0 (group accepted) and drain_done==1 in the same cycle.
REQ-027 stomp (any state, en ignored) SHALL clear grp_v/grp_lane_v next cycle, force q_pop=0, enter FLUSH.
REQ-028 FLUSH->RUN after exactly one cycle with stomp low; stomp held keeps FLUSH.
REQ-029 en low SHALL freeze all state except stomp handling; q_pop=0.
REQ-030 q_pop SHALL never exceed q_count; q_count==0 SHALL yield no load.
REQ-031 Simultaneous grp_rdy accept and new load SHALL replace the group in one cycle (full throughput).

Reset
REQ-032 On rst: grp_v=0, grp_lane_v=0, grp_uop=0, grp_seq=0, state=RUN; q_pop=0 while rst high.
REQ-033 Reset mid-DRAIN or mid-FLUSH SHALL return to RUN with no group pending.

Structure
REQ-034 micro_op_t, MWIDTH and mark-bit localparams (UOP_MARK_FIRST/LAST/SER) SHALL reside in Qupls4_pkg.
REQ-035 State enum SHALL be local to the module.
REQ-036 Take-count logic SHALL be one combinational sub-module, Qupls4_uop_group_select.

Verification
REQ-037 q_count=7, no serialize, grp_rdy=1 -> q_pop=4, then group lane_v=1111 seq=1; next load lane_v=0111 seq=2.
REQ-038 Serialize at lane2, q_count=4 -> q_pop=2 lane_v=0011; next cycle q_pop=1 lane_v=0001, DRAIN; no load until drain_done=1 after acceptance.
REQ-039 grp_rdy=0 for 3 cycles with q_count=8 -> q_pop=0 after first load, payload stable; grp_rdy=1 -> next group loads same cycle.
REQ-040 stomp while grp_v=1 -> grp_v=0 next cycle, q_pop=0, one FLUSH cycle, then loads resume, seq continues.
REQ-041 256 single-lane loads -> grp_seq wraps to 0; rst asserted mid-DRAIN -> all outputs zero, state RUN.

Source files
------------

// File: rtl/qupls4_uop_reader_pkg.sv
// Shared micro-op types and mark-bit positions for the Qupls4 front end.
// A micro-op is a packed opcode/argument pair so it can be carried as a plain bus.
package Qupls4_pkg;

  localparam int MWIDTH = 4;

  localparam int UOP_MARK_FIRST = 0;
  localparam int UOP_MARK_LAST  = 1;
  localparam int UOP_MARK_SER   = 2;

  typedef struct packed {
    logic [7:0]  opc;
    logic [23:0] arg;
  } micro_op_t;

endpackage

// File: rtl/qupls4_uop_reader_group_select.sv
// Works out how many queue-head entries form the next rename group.
// A serializing micro-op always travels alone, so the group is cut just before it.
import Qupls4_pkg::*;

module Qupls4_uop_group_select #(
  parameter int MWIDTH = Qupls4_pkg::MWIDTH
) (
  input  logic [3:0] q_count,
  input  logic [2:0] q_mark [MWIDTH],
  output logic [2:0] take,
  output logic       take_ser
);

  logic [3:0] avail;
  logic       found;

  always_comb begin
    avail    = (q_count > 4'(MWIDTH)) ? 4'(MWIDTH) : q_count;
    take     = avail[2:0];
    take_ser = 1'b0;
    found    = 1'b0;
    if (avail != 4'd0 && q_mark[0][UOP_MARK_SER]) begin
      take     = 3'd1;
      take_ser = 1'b1;
    end else begin
      for (int i = 1; i < MWIDTH; i++) begin
        if (!found && 4'(i) < avail && q_mark[i][UOP_MARK_SER]) begin
          take  = 3'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/qupls4_uop_reader.sv
// Pulls up to MWIDTH micro-ops per cycle off the queue head into a rename group.
// Handshake: grp_v/grp_rdy -- a group transfers on any cycle both are high; while
// grp_v is high and grp_rdy low the group payload, lane valids and seq hold still.
import Qupls4_pkg::*;

module qupls4_uop_reader #(
  parameter int MWIDTH = Qupls4_pkg::MWIDTH,
  parameter int QDEPTH = 12
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               en,
  input  logic               stomp,
  input  logic [3:0]         q_count,
  input  micro_op_t          q_uop [MWIDTH],
  input  logic [2:0]         q_mark [MWIDTH],
  output logic [2:0]         q_pop,
  output logic               grp_v,
  input  logic               grp_rdy,
  output micro_op_t          grp_uop [MWIDTH],
  output logic [MWIDTH-1:0]  grp_lane_v,
  output logic [7:0]         grp_seq,
  input  logic               drain_done,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              grp_v_q, grp_v_d;
  logic [MWIDTH-1:0] grp_lane_v_q, grp_lane_v_d;
  logic [7:0]        grp_seq_q, grp_seq_d;
  micro_op_t         grp_uop_q [MWIDTH];
  micro_op_t         grp_uop_d [MWIDTH];

  logic [3:0] q_cnt;
  logic [2:0] take;
  logic       take_ser;
  logic       load;

  // An out-of-range count from the queue can never claim more than it holds.
  assign q_cnt = (q_count > 4'(QDEPTH)) ? 4'(QDEPTH) : q_count;

  Qupls4_uop_group_select #(.MWIDTH(MWIDTH)) u_sel (
    .q_count  (q_cnt),
    .q_mark   (q_mark),
    .take     (take),
    .take_ser (take_ser)
  );

  assign load  = !rst && en && state_q == ST_RUN && !stomp && take != 3'd0 &&
                 (!grp_v_q || grp_rdy);
  assign q_pop = load ? take : 3'd0;

  always_comb begin
    state_d      = state_q;
    grp_v_d      = grp_v_q;
    grp_lane_v_d = grp_lane_v_q;
    grp_seq_d    = grp_seq_q;
    grp_uop_d    = grp_uop_q;
    if (stomp) begin
      grp_v_d      = 1'b0;
      grp_lane_v_d = '0;
      state_d      = ST_FLUSH;
    end else if (en) begin
      if (load) begin
        grp_v_d   = 1'b1;
        grp_seq_d = grp_seq_q + 8'd1;
        for (int i = 0; i < MWIDTH; i++) begin
          grp_lane_v_d[i] = 3'(i) < take;
          grp_uop_d[i]    = (3'(i) < take) ? q_uop[i] : '0;
        end
        if (take_ser) state_d = ST_DRAIN;
      end else if (grp_v_q && grp_rdy) begin
        grp_v_d      = 1'b0;
        grp_lane_v_d = '0;
      end
      // Leaving DRAIN needs the serialized group gone and the backend empty.
      if (state_q == ST_DRAIN && !grp_v_q && drain_done) state_d = ST_RUN;
      if (state_q == ST_FLUSH) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      grp_v_q      <= 1'b0;
      grp_lane_v_q <= '0;
      grp_seq_q    <= 8'd0;
      for (int i = 0; i < MWIDTH; i++) grp_uop_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grp_v_q      <= grp_v_d;
      grp_lane_v_q <= grp_lane_v_d;
      grp_seq_q    <= grp_seq_d;
      grp_uop_q    <= grp_uop_d;
    end
  end

  assign grp_v      = grp_v_q;
  assign grp_lane_v = grp_lane_v_q;
  assign grp_seq    = grp_seq_q;
  assign grp_uop    = grp_uop_q;
  assign dbg_state  = state_q;

endmodule
